// File: rtl/mux_arbiter_2to1_pkg.sv
// ============================================================================
// Module : mux_arbiter_2to1_pkg
// Brief  : Shared state encodings and sizing helper for the 2:1 mux arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;

  // Tenure counter width; a single-beat tenure still needs one bit.
  function automatic int cnt_width(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arbiter_2to1_datapath.sv
// ============================================================================
// Module : mux2_datapath
// Brief  : Combinational WIDTH-bit 2:1 select mux (S=0 -> I0, S=1 -> I1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux2_datapath #(
  parameter int WIDTH = 1
) (
  input  logic             S,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] out
);

  assign out = S ? I1 : I0;

endmodule

`default_nettype wire

// File: rtl/mux_arbiter_2to1.sv
// ============================================================================
// Module : mux_arbiter_2to1
// Brief  : Round-robin arbiter driving a 2:1 mux select, with a registered
//          valid/ready output stage. Define ARB_TAP_EN to add the tap port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_arbiter_2to1
  import mux_arbiter_2to1_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef ARB_TAP_EN
  ,
  output logic [8:0]       tap
`endif
);

  localparam int CNT_W = cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  arb_state_t       w_oth_state;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sel;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_mux;
  logic             w_own0;
  logic             w_own1;
  logic             w_req_own;
  logic             w_req_oth;
  logic             w_load;

  assign w_own0      = (r_state == ARB_OWN0);
  assign w_own1      = (r_state == ARB_OWN1);
  assign w_req_own   = w_own0 ? req0 : req1;
  assign w_req_oth   = w_own0 ? req1 : req0;
  assign w_oth_state = w_own0 ? ARB_OWN1 : ARB_OWN0;
  assign w_load      = ((w_own0 & req0) | (w_own1 & req1)) & (~r_out_valid | out_ready);

  mux2_datapath #(.WIDTH(WIDTH)) u_mux (
    .S  (r_sel),
    .I0 (d0),
    .I1 (d1),
    .out(w_mux)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_IDLE: begin
        w_cnt_nxt = '0;
        if (req0 && (!req1 || r_last)) begin
          w_state_nxt = ARB_OWN0;
        end else if (req1) begin
          w_state_nxt = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!w_req_own) begin
          // Owner withdrew: hand over after a bubble cycle with no grant.
          w_state_nxt = w_req_oth ? w_oth_state : ARB_IDLE;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_own1;
        end else if (w_load) begin
          if (w_req_oth && (r_cnt == c_cnt_max)) begin
            w_state_nxt = w_oth_state;
            w_cnt_nxt   = '0;
            w_last_nxt  = w_own1;
          end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_last <= w_last_nxt;
      r_cnt  <= w_cnt_nxt;
      // Select tracks the owner and keeps its last value through IDLE.
      if (w_state_nxt == ARB_OWN1) begin
        r_sel <= 1'b1;
      end else if (w_state_nxt == ARB_OWN0) begin
        r_sel <= 1'b0;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign gnt0      = w_load & w_own0;
  assign gnt1      = w_load & w_own1;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != ARB_IDLE);

`ifdef ARB_TAP_EN
  assign tap = {r_state, out_ready, r_out_valid, gnt1, gnt0, r_sel, req1, req0};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter_2to1.sv
// ============================================================================
// Module : tb_mux_arbiter_2to1
// Brief  : Directed and random checks of mux_arbiter_2to1 against a
//          beat-counting round-robin reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_arbiter_2to1;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1, sel, out_valid, busy;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef ARB_TAP_EN
  logic [8:0]       tap;
`endif

  always #5 clk = ~clk;

  mux_arbiter_2to1 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .d0       (d0),
    .d1       (d1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef ARB_TAP_EN
    ,
    .tap      (tap)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: owner (-1 = none), beats served in current tenure.
  int               m_own;
  int               m_last;
  int               m_beats;
  logic             m_sel;
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  bit               m_g0, m_g1;

  function automatic void model_reset();
    m_own = -1; m_last = 1; m_beats = 0;
    m_sel = 1'b0; m_ov = 1'b0; m_od = '0;
    m_g0 = 1'b0; m_g1 = 1'b0;
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic r0, input logic r1,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                      input logic rdy);
    logic             rq [2];
    logic [WIDTH-1:0] dd [2];
    logic             g;
    int               oth;
    @(negedge clk);
    req0 = r0; req1 = r1; d0 = a0; d1 = a1; out_ready = rdy;
    #1;
    rq[0] = r0; rq[1] = r1; dd[0] = a0; dd[1] = a1;
    g    = (m_own >= 0) && rq[m_own] && (!m_ov || rdy);
    m_g0 = g && (m_own == 0);
    m_g1 = g && (m_own == 1);
    check("cycle", 32'({gnt0, gnt1, sel, busy, out_valid, out_data}),
          32'({m_g0, m_g1, m_sel, ((m_own >= 0) ? 1'b1 : 1'b0), m_ov, m_od}));
    if (g) begin
      m_od = dd[m_own];
      m_ov = 1'b1;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (m_own < 0) begin
      if (r0 || r1) begin
        m_own   = (r0 && r1) ? ((m_last == 1) ? 0 : 1) : (r0 ? 0 : 1);
        m_beats = 0;
      end
    end else begin
      oth = 1 - m_own;
      if (!rq[m_own]) begin
        m_last  = m_own;
        m_own   = rq[oth] ? oth : -1;
        m_beats = 0;
      end else if (g) begin
        m_beats++;
        if (m_beats >= MAX_HOLD && rq[oth]) begin
          m_last  = m_own;
          m_own   = oth;
          m_beats = 0;
        end
      end
    end
    if (m_own == 0) m_sel = 1'b0;
    else if (m_own == 1) m_sel = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({gnt0, gnt1, busy, out_valid}), 32'h0);
    req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic             r0, r1, rdy;
    logic [WIDTH-1:0] a0, a1;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'({gnt0, gnt1, sel, busy, out_valid, out_data}), 32'h0);
    rst_n = 1'b1;

    // Single requester: grant at cycle 1, registered beat at cycle 2.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'h1, 4'h0, 1'b1);
      if (k == 0) check("single_gnt_c0", 32'(gnt0), 32'h0);
      if (k == 1) check("single_gnt_c1", 32'(gnt0), 32'h1);
      if (k == 2) check("single_out_c2", 32'({out_valid, out_data, sel}), 32'({1'b1, 4'h1, 1'b0}));
    end

    // Backpressure: stall three cycles, then grant in the same cycle as ready.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      check("bp_stall", 32'({gnt0, out_valid, out_data}), 32'({1'b0, 1'b1, 4'h1}));
    end
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    check("bp_release", 32'(gnt0), 32'h1);

    do_reset();

    // Tie with both requesters held high: bursts of MAX_HOLD, no bubbles.
    for (int k = 0; k < 13; k++) begin
      step(1'b1, 1'b1, 4'h5, 4'hA, 1'b1);
      check("tie_gnt", 32'({gnt0, gnt1}),
            32'({((k >= 1 && k <= 4) || (k >= 9 && k <= 12)), (k >= 5 && k <= 8)}));
`ifdef ARB_TAP_EN
      if (k >= 1 && k <= 4) check("tap_state_own0", 32'(tap[8:7]), 32'h1);
      if (k >= 5 && k <= 8) check("tap_state_own1", 32'(tap[8:7]), 32'h2);
      check("tap_gnt", 32'(tap[4:3]), 32'({gnt1, gnt0}));
`endif
    end

    do_reset();

    // Owner drops while the other requests: one bubble, then handover.
    step(1'b1, 1'b0, 4'h3, 4'h0, 1'b1);
    step(1'b1, 1'b0, 4'h3, 4'h0, 1'b1);
    check("drop_gnt0", 32'(gnt0), 32'h1);
    step(1'b0, 1'b1, 4'h0, 4'h6, 1'b1);
    check("drop_bubble", 32'({gnt0, gnt1, sel}), 32'h0);
    step(1'b0, 1'b1, 4'h0, 4'h6, 1'b1);
    check("drop_handover", 32'({gnt1, sel}), 32'h3);

    do_reset();

    // Random traffic: requesters hold data until granted, occasionally withdraw.
    r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
    for (int n = 0; n < 3000; n++) begin
      if (m_g0 || !r0) begin
        r0 = ($urandom % 3) != 0;
        a0 = WIDTH'($urandom);
      end else if (($urandom % 16) == 0) begin
        r0 = 1'b0;
      end
      if (m_g1 || !r1) begin
        r1 = ($urandom % 3) != 0;
        a1 = WIDTH'($urandom);
      end else if (($urandom % 16) == 0) begin
        r1 = 1'b0;
      end
      rdy = ($urandom % 4) != 0;
      step(r0, r1, a0, a1, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
